quiz_round_ctrl: RTL
====================

// Module: quiz_round_ctrl
// PURPOSE
//  Round controller that sits directly downstream of the settings stage. Consumes participants_number,
//  total_times, points_add, points_deduce and set_done. Runs one answer round at a time: host start,
//  per-second countdown, first-buzz arbitration, host judgement, and per-player score update.
//  Feeds the display and scoreboard logic.
// PARAMETERS
//  CLK_HZ   100_000_000  clk cycles per countdown second (prescaler terminal count + 1)
//  SCORE_W  8            width of each player score, unsigned
// PORTS
//  clk                  in   1         system clock
//  rst                  in   1         synchronous reset, active-low
//  set_done             in   1         settings complete; config inputs valid
//  participants_number  in   3         active players, 2..4
//  total_times          in   8         round length in seconds
//  points_add           in   4         score added on correct answer
//  points_deduce        in   4         score removed on wrong answer
//  start                in   1         host start pulse (clean, 1 cycle)
//  buzz                 in   4         player buttons, synchronised/debounced levels; bit k = player k+1
//  judge_ok             in   1         host: answer correct (1-cycle pulse)
//  judge_bad            in   1         host: answer wrong (1-cycle pulse)
//  phase                out  3         0 IDLE, 1 READY, 2 COUNT, 3 ANSWER, 4 TIMEOUT
//  winner               out  3         0 none, else 1..4 = player who holds the answer
//  time_left            out  8         seconds remaining
//  score_bus            out  4*SCORE_W player k score at [k*SCORE_W +: SCORE_W]
//  foul                 out  4         1-cycle per-player early-buzz pulse
// BEHAVIOUR
//  - Reset (rst=0 at posedge clk): phase=IDLE; winner, time_left, score_bus, foul = 0; prescaler and buzz history cleared.
//  - Buzz edges: rise = buzz & ~buzz_q. Eligible = bit index < latched participants count.
//  - IDLE: set_done=1 -> READY. In any state, set_done=0 -> IDLE; scores are kept.
//  - READY/TIMEOUT, start=1:
//    - Latch all four config inputs.
//    - time_left<=total_times; winner<=0; prescaler<=0; -> COUNT.
//  - COUNT:
//    - Prescaler counts 0..CLK_HZ-1; the wrap is a tick, and time_left decrements on each tick.
//    - First tick occurs exactly CLK_HZ cycles after the start cycle.
//    - time_left==1 on a tick -> time_left 0, -> TIMEOUT.
//    - total_times==0 -> TIMEOUT on the cycle after start.
//    - Eligible rise -> winner<=lowest eligible index+1, -> ANSWER; time_left freezes. Latency is 1 cycle.
//    - Buzz and final tick in the same cycle: the buzz wins (ANSWER, time_left kept at 1).
//    - start is ignored.
//  - ANSWER:
//    - judge_ok -> score[winner] += points_add, saturating at 2^SCORE_W-1; -> READY.
//    - judge_bad -> score[winner] -= points_deduce, floored at 0; -> READY.
//    - judge_ok and judge_bad together -> ignored, stay in ANSWER.
//    - Further buzzes are ignored. winner is held until the next start.
//  - Ineligible players never win, are never scored, and never foul.
//  - Scores are cleared only by rst.
// CONFIGURATION
//  FOUL_PENALTY_EN defined:
//    - In READY, each eligible rise pulses foul[k] for 1 cycle.
//    - score[k] -= points_deduce (floored at 0); simultaneous fouls are each penalised.
//    - READY uses the live config inputs.
//  FOUL_PENALTY_EN undefined: buzzes in READY are ignored; foul is tied to 0.
// TESTING (CLK_HZ=4 in bench)
//  1 Hold rst=0 for 2 cycles -> phase=0, winner=0, time_left=0, score_bus=0, foul=0.
//  2 set_done=1, participants=3, total=5, add=2, deduct=1. Start; buzz[1] rises after 8 cycles
//    -> winner=2, time_left=3 frozen. judge_ok -> score1=2, phase=1.
//  3 Start, then buzz=4'b1010 in one cycle -> winner=2. Next round, only buzz[3] -> ignored, stays COUNT.
//  4 Start, no buzz -> time_left 5..0, one step every 4 cycles; phase=4 at 20 cycles after start.
//    Start again -> time_left=5.
//  5 score1=1, deduct=3, judge_bad -> 0. score0=250, add=9, judge_ok -> 255 (saturates).
//  6 FOUL_PENALTY_EN: buzz[0] in READY, score0=4 -> foul=0001 for 1 cycle, score0=3.
//    Without the macro -> no change.

Source files
------------

// File: rtl/quiz_round_ctrl.sv
// quiz_round_ctrl
//   Answer-round controller: host start, per-second countdown, first-buzz
//   arbitration among the active players, host judgement and saturating
//   per-player score update. Scores survive everything except rst.
//
//   Optional build macro FOUL_PENALTY_EN: an eligible buzz while READY
//   raises a 1-cycle foul pulse for that player and deducts points_deduce
//   (live input) from that player's score. Without the macro, buzzes in
//   READY are ignored and foul is tied to 0.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   S_IDLE    | settings not complete, waiting for set_done
//   S_READY   | settings valid, waiting for host start
//   S_COUNT   | countdown running, first eligible buzz takes the answer
//   S_ANSWER  | winner holds the answer, waiting for host judgement
//   S_TIMEOUT | countdown expired with no buzz, start begins a new round
module quiz_round_ctrl #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCORE_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_done,
  input  logic [2:0]           participants_number,
  input  logic [7:0]           total_times,
  input  logic [3:0]           points_add,
  input  logic [3:0]           points_deduce,
  input  logic                 start,
  input  logic [3:0]           buzz,
  input  logic                 judge_ok,
  input  logic                 judge_bad,
  output logic [2:0]           phase,
  output logic [2:0]           winner,
  output logic [7:0]           time_left,
  output logic [4*SCORE_W-1:0] score_bus,
  output logic [3:0]           foul
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READY   = 3'd1,
    S_COUNT   = 3'd2,
    S_ANSWER  = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  localparam int              PRE_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(CLK_HZ - 1);

  state_t             state;
  logic [PRE_W-1:0]   presc;
  logic [3:0]         buzz_q;
  logic [2:0]         cfg_players;
  logic [3:0]         cfg_add;
  logic [3:0]         cfg_deduce;
  logic [SCORE_W-1:0] score [4];

  logic [3:0]         rise;
  logic [3:0]         elig_cfg;
  logic               win_hit;
  logic [2:0]         win_id;
  logic [1:0]         widx;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                 input logic [3:0] p);
    logic [SCORE_W:0] sum;
    sum = {1'b0, s} + (SCORE_W+1)'(p);
    return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  endfunction

  function automatic logic [SCORE_W-1:0] sat_sub(input logic [SCORE_W-1:0] s,
                                                 input logic [3:0] p);
    return (s < SCORE_W'(p)) ? '0 : s - SCORE_W'(p);
  endfunction

  assign rise  = buzz & ~buzz_q;
  assign phase = state;
  // winner is 1..4 while in ANSWER; the wrap of 4 onto index 3 is intended
  assign widx  = winner[1:0] - 2'd1;

  // Eligibility against the round's latched player count, lowest index wins
  always_comb begin
    elig_cfg = '0;
    win_hit  = 1'b0;
    win_id   = 3'd0;
    for (int k = 0; k < 4; k++) begin
      elig_cfg[k] = (3'(k) < cfg_players);
    end
    for (int k = 3; k >= 0; k--) begin
      if (rise[k] && elig_cfg[k]) begin
        win_hit = 1'b1;
        win_id  = 3'(k + 1);
      end
    end
  end

  // Flatten the score registers onto the output bus
  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_bus
      assign score_bus[g*SCORE_W +: SCORE_W] = score[g];
    end
  endgenerate

`ifdef FOUL_PENALTY_EN
  logic [3:0] elig_live;
  logic [3:0] foul_q;

  assign foul = foul_q;

  // Early-buzz detection uses the live player count since no round is latched yet
  always_comb begin
    elig_live = '0;
    for (int k = 0; k < 4; k++) begin
      elig_live[k] = (3'(k) < participants_number);
    end
  end
`else
  assign foul = '0;
`endif

  // Round sequencing, countdown, arbitration, scoring and buzz edge history
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      presc       <= '0;
      buzz_q      <= '0;
      winner      <= '0;
      time_left   <= '0;
      cfg_players <= '0;
      cfg_add     <= '0;
      cfg_deduce  <= '0;
      for (int k = 0; k < 4; k++) score[k] <= '0;
`ifdef FOUL_PENALTY_EN
      foul_q      <= '0;
`endif
    end else begin
      buzz_q <= buzz;
`ifdef FOUL_PENALTY_EN
      foul_q <= '0;
`endif
      if (!set_done) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: state <= S_READY;

          S_READY, S_TIMEOUT: begin
            if (start) begin
              cfg_players <= participants_number;
              cfg_add     <= points_add;
              cfg_deduce  <= points_deduce;
              time_left   <= total_times;
              winner      <= '0;
              presc       <= '0;
              // a zero-length round has nothing to count, expire right away
              state       <= (total_times == 8'd0) ? S_TIMEOUT : S_COUNT;
            end
`ifdef FOUL_PENALTY_EN
            if (state == S_READY) begin
              for (int k = 0; k < 4; k++) begin
                if (rise[k] && elig_live[k]) begin
                  foul_q[k] <= 1'b1;
                  score[k]  <= sat_sub(score[k], points_deduce);
                end
              end
            end
`endif
          end

          S_COUNT: begin
            // a buzz beats a coincident final tick, so time_left stays put
            if (win_hit) begin
              winner <= win_id;
              state  <= S_ANSWER;
            end else if (presc == PRE_TC) begin
              presc     <= '0;
              time_left <= time_left - 8'd1;
              if (time_left == 8'd1) state <= S_TIMEOUT;
            end else begin
              presc <= presc + PRE_W'(1);
            end
          end

          S_ANSWER: begin
            if (judge_ok && !judge_bad) begin
              score[widx] <= sat_add(score[widx], cfg_add);
              state       <= S_READY;
            end else if (judge_bad && !judge_ok) begin
              score[widx] <= sat_sub(score[widx], cfg_deduce);
              state       <= S_READY;
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
